// File: rtl/friet_round_if.sv
// Control handshake between the Friet round sequencer and the state-register datapath/consumer.
// The master modport is the controller side; the slave modport is the datapath/environment side.
interface friet_round_if #(
    parameter int CNT_WIDTH = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic                 load_en;
    logic                 perm_en;
    logic [CNT_WIDTH-1:0] round_idx;
    logic                 round_last;
    logic                 busy;

    modport master (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid,
        output load_en,
        output perm_en,
        output round_idx,
        output round_last,
        output busy
    );

    modport slave (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  load_en,
        input  perm_en,
        input  round_idx,
        input  round_last,
        input  busy
    );
endinterface

// File: rtl/friet_round_controller.sv
// Round sequencer for the Friet permutation: loads the state register, steps the round index,
// then holds the finished state under a valid/ready handshake. Carries no state data.
module friet_round_controller #(
    parameter int NUM_ROUNDS       = 24,
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int CNT_WIDTH        = 5
) (
    input  logic          clk,
    input  logic          rst,
    friet_round_if.master ctrl_if
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_ROUNDS - ROUNDS_PER_CYCLE);
    localparam logic [CNT_WIDTH-1:0] IDX_STEP = CNT_WIDTH'(ROUNDS_PER_CYCLE);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] idx_q, idx_d;
    logic                 last_w;
    logic                 in_ready_w;

    assign last_w     = (state_q == RUN) && (idx_q == LAST_IDX);
    assign in_ready_w = (state_q == IDLE) || ((state_q == HOLD) && ctrl_if.out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // The index is only advanced in RUN, so it is zero in IDLE/HOLD and never wraps.
    always_comb begin
        state_d = state_q;
        idx_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (ctrl_if.in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_w) begin
                    state_d = HOLD;
                end else begin
                    idx_d = idx_q + IDX_STEP;
                end
            end
            HOLD: begin
                if (ctrl_if.out_ready) begin
                    state_d = ctrl_if.in_valid ? RUN : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ctrl_if.in_ready   = in_ready_w;
        ctrl_if.load_en    = ctrl_if.in_valid && in_ready_w;
        ctrl_if.perm_en    = (state_q == RUN);
        ctrl_if.busy       = (state_q == RUN);
        ctrl_if.out_valid  = (state_q == HOLD);
        ctrl_if.round_idx  = idx_q;
        ctrl_if.round_last = last_w;
    end

endmodule

// File: tb/tb_friet_round_controller.sv
// Directed bench for friet_round_controller: one instance with default rounds per cycle,
// one unrolled by four, sharing clock and reset.
module tb_friet_round_controller;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    friet_round_if #(.CNT_WIDTH(5)) busA ();
    friet_round_if #(.CNT_WIDTH(5)) busB ();

    friet_round_controller #(
        .NUM_ROUNDS(24), .ROUNDS_PER_CYCLE(1), .CNT_WIDTH(5)
    ) dutA (
        .clk(clk), .rst(rst), .ctrl_if(busA)
    );

    friet_round_controller #(
        .NUM_ROUNDS(24), .ROUNDS_PER_CYCLE(4), .CNT_WIDTH(5)
    ) dutB (
        .clk(clk), .rst(rst), .ctrl_if(busB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after the falling edge; outputs are settled 1 time unit later.
    task automatic applyStimulus(input logic ivA, input logic orA, input logic ivB, input logic orB);
        @(negedge clk);
        busA.in_valid  = ivA;
        busA.out_ready = orA;
        busB.in_valid  = ivB;
        busB.out_ready = orB;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        busA.in_valid  = 1'b0;
        busA.out_ready = 1'b0;
        busB.in_valid  = 1'b0;
        busB.out_ready = 1'b0;
        #1;
        checkOutput("rstA_in_ready",   8'(busA.in_ready),   8'd1);
        checkOutput("rstA_out_valid",  8'(busA.out_valid),  8'd0);
        checkOutput("rstA_load_en",    8'(busA.load_en),    8'd0);
        checkOutput("rstA_perm_en",    8'(busA.perm_en),    8'd0);
        checkOutput("rstA_round_last", 8'(busA.round_last), 8'd0);
        checkOutput("rstA_busy",       8'(busA.busy),       8'd0);
        checkOutput("rstA_round_idx",  8'(busA.round_idx),  8'd0);
        checkOutput("rstB_busy",       8'(busB.busy),       8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Single permutation with out_ready high, default configuration.
        $display("[TB] single permutation, one round per cycle");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("acc_load_en",  8'(busA.load_en),  8'd1);
        checkOutput("acc_in_ready", 8'(busA.in_ready), 8'd1);
        checkOutput("acc_perm_en",  8'(busA.perm_en),  8'd0);
        for (int k = 1; k <= 24; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput("run_perm_en",    8'(busA.perm_en),    8'd1);
            checkOutput("run_busy",       8'(busA.busy),       8'd1);
            checkOutput("run_in_ready",   8'(busA.in_ready),   8'd0);
            checkOutput("run_out_valid",  8'(busA.out_valid),  8'd0);
            checkOutput("run_round_idx",  8'(busA.round_idx),  8'(k - 1));
            checkOutput("run_round_last", 8'(busA.round_last), (k == 24) ? 8'd1 : 8'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("done_out_valid", 8'(busA.out_valid), 8'd1);
        checkOutput("done_perm_en",   8'(busA.perm_en),   8'd0);
        checkOutput("done_in_ready",  8'(busA.in_ready),  8'd1);
        checkOutput("done_round_idx", 8'(busA.round_idx), 8'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("idle_out_valid", 8'(busA.out_valid), 8'd0);
        checkOutput("idle_busy",      8'(busA.busy),      8'd0);

        // Four rounds per cycle on the second instance.
        $display("[TB] four rounds per cycle");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("b_acc_load_en", 8'(busB.load_en), 8'd1);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput("b_run_perm_en",    8'(busB.perm_en),    8'd1);
            checkOutput("b_run_round_idx",  8'(busB.round_idx),  8'((k - 1) * 4));
            checkOutput("b_run_round_last", 8'(busB.round_last), (k == 6) ? 8'd1 : 8'd0);
            checkOutput("b_run_out_valid",  8'(busB.out_valid),  8'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("b_done_out_valid", 8'(busB.out_valid), 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("b_idle_out_valid", 8'(busB.out_valid), 8'd0);

        // Consumer stalls for ten cycles; in_valid pulses must be ignored.
        $display("[TB] output back-pressure");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_acc_load_en", 8'(busA.load_en), 8'd1);
        for (int k = 1; k <= 24; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 10; k++) begin
            applyStimulus(logic'(k % 2), 1'b0, 1'b0, 1'b0);
            checkOutput("bp_out_valid", 8'(busA.out_valid), 8'd1);
            checkOutput("bp_in_ready",  8'(busA.in_ready),  8'd0);
            checkOutput("bp_perm_en",   8'(busA.perm_en),   8'd0);
            checkOutput("bp_load_en",   8'(busA.load_en),   8'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_rel_out_valid", 8'(busA.out_valid), 8'd1);
        checkOutput("bp_rel_in_ready",  8'(busA.in_ready),  8'd1);
        checkOutput("bp_rel_load_en",   8'(busA.load_en),   8'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_idle_out_valid", 8'(busA.out_valid), 8'd0);
        checkOutput("bp_idle_busy",      8'(busA.busy),      8'd0);
        checkOutput("bp_idle_perm_en",   8'(busA.perm_en),   8'd0);

        // Back-to-back: new input accepted in the same cycle the result is taken.
        $display("[TB] back-to-back permutations");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("bb_acc_load_en", 8'(busA.load_en), 8'd1);
        for (int k = 1; k <= 24; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("bb_first_out_valid", 8'(busA.out_valid), 8'd1);
        checkOutput("bb_hold_in_ready",   8'(busA.in_ready),  8'd1);
        checkOutput("bb_hold_load_en",    8'(busA.load_en),   8'd1);
        checkOutput("bb_hold_perm_en",    8'(busA.perm_en),   8'd0);
        for (int k = 1; k <= 24; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput("bb_run_out_valid", 8'(busA.out_valid), 8'd0);
            checkOutput("bb_run_round_idx", 8'(busA.round_idx), 8'(k - 1));
            checkOutput("bb_run_perm_en",   8'(busA.perm_en),   8'd1);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("bb_second_out_valid", 8'(busA.out_valid), 8'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("bb_idle_out_valid", 8'(busA.out_valid), 8'd0);

        // Asynchronous reset in the middle of a run aborts it.
        $display("[TB] reset during run");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("ar_acc_load_en", 8'(busA.load_en), 8'd1);
        for (int k = 1; k <= 11; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("ar_pre_round_idx", 8'(busA.round_idx), 8'd10);
        checkOutput("ar_pre_perm_en",   8'(busA.perm_en),   8'd1);
        rst = 1'b1;
        #1;
        checkOutput("ar_in_ready",  8'(busA.in_ready),  8'd1);
        checkOutput("ar_out_valid", 8'(busA.out_valid), 8'd0);
        checkOutput("ar_perm_en",   8'(busA.perm_en),   8'd0);
        checkOutput("ar_round_idx", 8'(busA.round_idx), 8'd0);
        checkOutput("ar_busy",      8'(busA.busy),      8'd0);
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput("ar_no_out_valid", 8'(busA.out_valid), 8'd0);
            checkOutput("ar_idle_in_ready", 8'(busA.in_ready), 8'd1);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("ar_new_load_en", 8'(busA.load_en), 8'd1);
        for (int k = 1; k <= 24; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput("ar_new_out_valid_low", 8'(busA.out_valid), 8'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("ar_new_out_valid", 8'(busA.out_valid), 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
